// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/execute states and drives all datapath enables.
// Optional immediate ALU ops (addi/andi/ori/slti) are enabled by defining MC_CTRL_IMM_OPS_EN.
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ext_zero,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic       PCEn,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALUC_W = 4;

    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_IMM_OPS_EN
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
`endif

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [OP_W-1:0]   r_func_q;
    logic [OP_W-1:0]   r_op_q;
    logic              w_pc_write;
    logic              w_branch;
    logic              w_funct_ok;

    // R-type funct legality, evaluated on the live IR during DECODE
    always_comb begin
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: w_funct_ok = 1'b1;
            default:                                       w_funct_ok = 1'b0;
        endcase
    end

    // State register; funct and opcode are captured in DECODE so later IR changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_func_q <= '0;
            r_op_q   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_func_q <= funct;
                r_op_q   <= opcode;
            end
        end
    end

    // Next-state and Moore output decode; reset forces every output to its default
    always_comb begin
        w_next_state = S_FETCH;
        ALUControl   = ALU_ADD;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ext_zero     = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = 1'b1;
                    ALUSrcB      = 2'b01;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_RTYPE: begin
                            if (w_funct_ok) begin
                                w_next_state = S_EXEC;
                            end else begin
                                illegal_op = 1'b1;
                                instr_done = 1'b1;
                            end
                        end
                        OP_LW, OP_SW: w_next_state = S_MEMADR;
                        OP_BEQ:       w_next_state = S_BRANCH;
                        OP_J:         w_next_state = S_JUMP;
`ifdef MC_CTRL_IMM_OPS_EN
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next_state = S_IEXEC;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b10;
                    w_next_state = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    IorD         = 1'b1;
                    MemRead      = 1'b1;
                    w_next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    case (r_func_q)
                        FN_SUB:  ALUControl = ALU_SUB;
                        FN_AND:  ALUControl = ALU_AND;
                        FN_OR:   ALUControl = ALU_OR;
                        FN_SLT:  ALUControl = ALU_SLT;
                        FN_NOR:  ALUControl = ALU_NOR;
                        default: ALUControl = ALU_ADD;
                    endcase
                    w_next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSource   = 2'b01;
                    w_branch   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSource   = 2'b10;
                    w_pc_write = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MC_CTRL_IMM_OPS_EN
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (r_op_q)
                        OP_ANDI: begin
                            ALUControl = ALU_AND;
                            ext_zero   = 1'b1;
                        end
                        OP_ORI: begin
                            ALUControl = ALU_OR;
                            ext_zero   = 1'b1;
                        end
                        OP_SLTI: ALUControl = ALU_SLT;
                        default: ALUControl = ALU_ADD;
                    endcase
                    w_next_state = S_IWB;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: w_next_state = S_FETCH;
            endcase
        end

        PCEn = w_pc_write | (w_branch & zero);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; every cycle compares the full output bundle
// against hand-written per-state vectors.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ext_zero;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic [1:0] PCSource;
    logic       PCEn;
    logic       instr_done;
    logic       illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ext_zero   (ext_zero),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .PCSource   (PCSource),
        .PCEn       (PCEn),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] w_outs;
    assign w_outs = {ALUControl, ALUSrcA, ALUSrcB, ext_zero, IorD, MemRead, MemWrite, IRWrite,
                     RegDst, MemtoReg, RegWrite, PCSource, PCEn, instr_done, illegal_op};

    function automatic logic [19:0] pack(
        input logic [3:0] alu, input logic sa, input logic [1:0] sb, input logic ez,
        input logic iord, input logic mr, input logic mw, input logic irw,
        input logic rd, input logic m2r, input logic rw, input logic [1:0] pcs,
        input logic pcen, input logic done, input logic ill);
        return {alu, sa, sb, ez, iord, mr, mw, irw, rd, m2r, rw, pcs, pcen, done, ill};
    endfunction

    logic [19:0] V_RESET, V_FETCH, V_DECODE, V_DEC_ILL, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
    logic [19:0] V_ALUWB, V_BR_T, V_BR_N, V_JUMP, V_IWB;

    function automatic logic [19:0] v_exec(input logic [3:0] alu);
        return pack(alu, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fn_tbl  [6];
    logic [3:0] alu_tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 alu      sa    sb     ez    iord  mr    mw    irw   rd    m2r   rw    pcs    pcen  done  ill
        V_RESET   = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        V_FETCH   = pack(4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        V_DECODE  = pack(4'b0010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        V_DEC_ILL = pack(4'b0010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        V_MEMADR  = pack(4'b0010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        V_MEMRD   = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        V_MEMWB   = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        V_MEMWR   = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        V_ALUWB   = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        V_BR_T    = pack(4'b0110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
        V_BR_N    = pack(4'b0110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        V_JUMP    = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        V_IWB     = pack(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);

        fn_tbl  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        alu_tbl = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

        // Reset held for two edges
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b1;
        #1;
        chk("reset_hold", w_outs, V_RESET);
        tick();
        tick();
        chk("reset_hold2", w_outs, V_RESET);
        reset = 1'b0;
        zero  = 1'b0;
        #1;
        chk("fetch_after_reset", w_outs, V_FETCH);

        // sub, with IR garbage after DECODE to prove func_q is used
        funct = 6'b100010;
        tick(); chk("sub_decode", w_outs, V_DECODE);
        tick(); funct = 6'b111111; #1;
        chk("sub_exec", w_outs, v_exec(4'b0110));
        tick(); chk("sub_aluwb", w_outs, V_ALUWB);
        tick(); chk("sub_fetch", w_outs, V_FETCH);

        // all six R-type functions
        for (int i = 0; i < 6; i++) begin
            opcode = 6'b000000;
            funct  = fn_tbl[i];
            tick(); chk($sformatf("r%0d_decode", i), w_outs, V_DECODE);
            tick(); chk($sformatf("r%0d_exec", i), w_outs, v_exec(alu_tbl[i]));
            tick(); chk($sformatf("r%0d_aluwb", i), w_outs, V_ALUWB);
            tick(); chk($sformatf("r%0d_fetch", i), w_outs, V_FETCH);
        end

        // lw, opcode changed in MEMADR must not redirect to MEMWR
        opcode = 6'b100011;
        tick(); chk("lw_decode", w_outs, V_DECODE);
        tick(); opcode = 6'b101011; #1;
        chk("lw_memadr", w_outs, V_MEMADR);
        tick(); chk("lw_memrd", w_outs, V_MEMRD);
        tick(); chk("lw_memwb", w_outs, V_MEMWB);
        tick(); chk("lw_fetch", w_outs, V_FETCH);

        // beq taken
        opcode = 6'b000100;
        tick(); chk("beq1_decode", w_outs, V_DECODE);
        tick(); zero = 1'b1; #1;
        chk("beq1_branch", w_outs, V_BR_T);
        tick(); chk("beq1_fetch", w_outs, V_FETCH);

        // beq not taken
        tick(); chk("beq2_decode", w_outs, V_DECODE);
        tick(); zero = 1'b0; #1;
        chk("beq2_branch", w_outs, V_BR_N);
        tick(); chk("beq2_fetch", w_outs, V_FETCH);

        // j
        opcode = 6'b000010;
        tick(); chk("j_decode", w_outs, V_DECODE);
        tick(); chk("j_jump", w_outs, V_JUMP);
        tick(); chk("j_fetch", w_outs, V_FETCH);

        // illegal opcode
        opcode = 6'b111111;
        tick(); chk("badop_decode", w_outs, V_DEC_ILL);
        tick(); chk("badop_fetch", w_outs, V_FETCH);

        // illegal R-type funct
        opcode = 6'b000000;
        funct  = 6'b000000;
        tick(); chk("badfn_decode", w_outs, V_DEC_ILL);
        tick(); chk("badfn_fetch", w_outs, V_FETCH);

`ifdef MC_CTRL_IMM_OPS_EN
        // ori
        opcode = 6'b001101;
        tick(); chk("ori_decode", w_outs, V_DECODE);
        tick(); chk("ori_iexec", w_outs,
                    pack(4'b0001, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        tick(); chk("ori_iwb", w_outs, V_IWB);
        tick(); chk("ori_fetch", w_outs, V_FETCH);
`else
        // addi is not supported without the immediate-op option
        opcode = 6'b001000;
        tick(); chk("addi_decode", w_outs, V_DEC_ILL);
        tick(); chk("addi_fetch", w_outs, V_FETCH);
        if (V_IWB === 20'h0) chk("iwb_vec_unused", V_IWB, 20'h1);
`endif

        // sw interrupted by reset in MEMWR
        opcode = 6'b101011;
        tick(); chk("sw_decode", w_outs, V_DECODE);
        tick(); chk("sw_memadr", w_outs, V_MEMADR);
        tick(); chk("sw_memwr", w_outs, V_MEMWR);
        reset = 1'b1;
        #1;
        chk("sw_reset_cycle", w_outs, V_RESET);
        tick();
        reset = 1'b0;
        #1;
        chk("sw_reset_fetch", w_outs, V_FETCH);

        // normal sequencing resumes after the abandoned store
        opcode = 6'b000010;
        tick(); chk("post_decode", w_outs, V_DECODE);
        tick(); chk("post_jump", w_outs, V_JUMP);
        tick(); chk("post_fetch", w_outs, V_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS control unit. It drives the ALU's 4-bit ALUControl input and consumes the ALU's zero flag. It is the controlling end of the ALU interface.
- Sequences each instruction through FETCH, DECODE and execute states.
- Produces all datapath enables: PC, instruction register, memory, register file and mux selects.
- Sits between the instruction register (opcode/funct) and the shared-memory multicycle datapath.

Parameters:
None. ALU opcode encoding is fixed: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 1100.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register; valid from DECODE onward
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag (combinational, same cycle)
- ALUControl  output  4  ALU operation select
- ALUSrcA  output  1  0=PC, 1=register A
- ALUSrcB  output  2  00=register B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
- ext_zero  output  1  1=zero-extend the immediate instead of sign-extending
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  destination register: 0=rt, 1=rd
- MemtoReg  output  1  write-back data: 0=ALUOut, 1=MDR
- RegWrite  output  1  register file write enable
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- PCEn  output  1  PC load enable = PCWrite OR (Branch AND zero)
- instr_done  output  1  1-cycle pulse in the last state of each instruction
- illegal_op  output  1  1-cycle pulse in DECODE for an unsupported opcode or funct

Behaviour:
- Outputs are a Moore decode of the state register. The only exception is PCEn in BRANCH, which also depends on zero.
- Unlisted outputs are 0 in every state; ALUControl defaults to 0010.
- Reset:
  - reset high at a clk edge puts state into FETCH; this also applies mid-instruction, and the partial instruction is abandoned.
  - While reset is high, PCEn, IRWrite, MemWrite and RegWrite are forced to 0, and MemRead, instr_done and illegal_op are 0.
  - ALUControl=0010 while reset is high.
- FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=0010, PCSource=00, PCEn=1. Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUControl=0010 (computes the branch target).
  - Latches funct into an internal register func_q.
  - Next state by opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 and instr_done=1
  - R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor} -> FETCH, with illegal_op=1 and instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=0010. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Next state: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state: FETCH.
- MEMWR: IorD=1, MemWrite=1, instr_done=1. Next state: FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from func_q (add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100). Next state: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=0110, PCSource=01, PCEn=zero, instr_done=1. Next state: FETCH.
- JUMP: PCSource=10, PCEn=1, instr_done=1. Next state: FETCH.
- Latency in cycles, counted from FETCH up to and including the done state:
  - beq, j: 3
  - R-type, sw: 4
  - lw: 5
  - illegal opcode/funct: 2
- State encoding uses 4 bits. Unreachable encodings go to FETCH on the next edge with all outputs at their defaults.
- opcode and funct are ignored outside DECODE. EXEC uses func_q only, so IR changes after DECODE have no effect.

Optional Feature:
Macro: MC_CTRL_IMM_OPS_EN
- Defined: DECODE additionally accepts the following opcodes and goes to IEXEC:
  - 001000 addi: ALUControl 0010, sign-extended immediate
  - 001100 andi: ALUControl 0000, ext_zero=1
  - 001101 ori: ALUControl 0001, ext_zero=1
  - 001010 slti: ALUControl 0111, sign-extended immediate
- DECODE latches the opcode for IEXEC.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl and ext_zero as listed above. Next state: IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state: FETCH. Immediate-op latency is 4.
- Undefined: these opcodes are illegal (illegal_op pulse, return to FETCH). ext_zero is tied to 0.

Test Plan:
- Reset for 2 cycles, then release -> first cycle after release: FETCH outputs (MemRead=1, IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=0010).
- opcode=000000, funct=100010 -> EXEC shows ALUControl=0110; ALUWB shows RegWrite=1, RegDst=1; instr_done on cycle 4.
- lw (100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMRD has IorD=1, MemRead=1; MEMWB has MemtoReg=1, RegWrite=1; 5 cycles total.
- beq with zero=1, then beq with zero=0 -> BRANCH shows ALUControl=0110, PCSource=01; PCEn=1 for zero=1 and PCEn=0 for zero=0.
- opcode=111111, then R-type funct=000000 -> each gives illegal_op=1 in DECODE, returns to FETCH, and never asserts RegWrite or MemWrite.
- reset asserted in MEMWR of sw -> MemWrite=0 during the reset cycle, FETCH on the next edge. With MC_CTRL_IMM_OPS_EN defined: ori gives ext_zero=1, ALUControl=0001 in IEXEC.
